// File: rtl/debug_uart_pkg.sv
// Shared types, ASCII constants and the nibble-to-ASCII helper for the debug UART.
package debug_uart_pkg;

  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [2:0] LAST_CHAR = 3'd5;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' (uppercase only).
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/debug_hex_uart_tx_byte.sv
// 8N1 byte serializer: owns the baud and bit counters and drives a registered txp.
module uart_tx_byte #(
  parameter int BAUD_DIV = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txp,
  output logic       done
);

  localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [W-1:0] BAUD_LAST = W'(BAUD_DIV - 1);
  localparam logic [3:0]   STOP_BIT  = 4'd9;

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_byte: BAUD_DIV must be at least 2");
    end
  endgenerate

  logic         active;
  logic [W-1:0] baud_cnt;
  logic [3:0]   bit_cnt;
  logic [8:0]   frame;   // remaining data bits with the stop bit shifted in behind them

  logic bit_end;
  assign bit_end = active && (baud_cnt == BAUD_LAST);
  assign done    = bit_end && (bit_cnt == STOP_BIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= '0;
      txp      <= 1'b1;
    end else if (start) begin
      // A new byte may start on the same edge that ends the previous stop bit.
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      frame    <= {1'b1, data};
      txp      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == STOP_BIT) begin
          active <= 1'b0;
          txp    <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          txp     <= frame[0];
          frame   <= {1'b1, frame[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/debug_hex_uart_tx.sv
// Prints a 16-bit debug word as four uppercase hex digits plus CR LF over 8N1 serial.
module debug_hex_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        txp
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;

  tx_state_t   state;
  logic [15:0] hold;
  logic [2:0]  char_idx;

  logic        accept;
  logic        byte_done;
  logic        byte_start;
  logic [7:0]  byte_data;

  function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [15:0] word);
    case (idx)
      3'd0:    return hex_ascii(word[15:12]);
      3'd1:    return hex_ascii(word[11:8]);
      3'd2:    return hex_ascii(word[7:4]);
      3'd3:    return hex_ascii(word[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == SEND);
  assign accept   = in_ready && in_valid;

  // Char 0 is taken straight from in_data so its start bit lands in the cycle after accept.
  always_comb begin
    byte_start = 1'b0;
    byte_data  = char_of(char_idx + 3'd1, hold);
    if (accept) begin
      byte_start = 1'b1;
      byte_data  = char_of(3'd0, in_data);
    end else if (busy && byte_done && (char_idx != LAST_CHAR)) begin
      byte_start = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= '0;
      char_idx <= '0;
    end else if (accept) begin
      state    <= SEND;
      hold     <= in_data;
      char_idx <= '0;
    end else if (busy && byte_done) begin
      if (char_idx == LAST_CHAR) begin
        state    <= IDLE;
        char_idx <= '0;
      end else begin
        char_idx <= char_idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk   (clk),
    .reset (reset),
    .start (byte_start),
    .data  (byte_data),
    .txp   (txp),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_debug_hex_uart_tx.sv
// Self-checking bench: table of debug words with hand-computed ASCII frames, plus reset corner cases.
module tb_debug_hex_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int D      = 10;   // expected bit period in cycles

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic        busy;
  logic        txp;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] word;
    logic [47:0] exp;        // six expected bytes, first char in the top byte
    int          mode;       // 0 plain, 1 scramble in_data, 2 BEEF pulse during char 2
    bit          hold_next;  // keep in_valid high with next_word for back-to-back
    logic [15:0] next_word;
  } vec_t;

  vec_t vecs[6];

  debug_hex_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .txp      (txp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic idle_check(input int n, input string name);
    int errs = 0;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ({txp, in_ready, busy} !== 3'b110) errs++;
    end
    check(name, errs, 0);
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_msg(input vec_t v, input int tag);
    int          terr[6];
    logic [7:0]  got[6];
    logic [7:0]  eb;
    int          ctl_err = 0;
    int          idx, c, k;
    logic        expb;
    for (int i = 0; i < 6; i++) begin
      terr[i] = 0;
      got[i]  = 8'h00;
    end
    in_valid = 1'b1;
    in_data  = v.word;
    @(posedge clk);
    for (int j = 1; j <= 60 * D; j++) begin
      @(negedge clk);
      if (j == 1) begin
        in_valid = v.hold_next;
        if (v.hold_next) in_data = v.next_word;
      end
      if (v.mode == 1) in_data = 16'($urandom);
      if (v.mode == 2 && j == 20 * D + 3) begin
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
      end
      if (v.mode == 2 && j == 20 * D + 4) in_valid = 1'b0;
      idx = j - 1;
      c   = idx / (10 * D);
      k   = (idx % (10 * D)) / D;
      eb  = v.exp[47 - 8 * c -: 8];
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : eb[k - 1];
      if (txp !== expb) terr[c]++;
      if (k >= 1 && k <= 8 && (idx % D) == D / 2) got[c][k - 1] = txp;
      if (busy !== 1'b1 || in_ready !== 1'b0) ctl_err++;
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      eb = v.exp[47 - 8 * i -: 8];
      check($sformatf("msg%0d char%0d byte", tag, i), 32'(got[i]), 32'(eb));
      check($sformatf("msg%0d char%0d bit timing errors", tag, i), terr[i], 0);
    end
    check($sformatf("msg%0d busy/ready while sending", tag), ctl_err, 0);
    check($sformatf("msg%0d idle after 60 bits {busy,ready,txp}", tag),
          32'({busy, in_ready, txp}), 32'(3'b011));
  endtask

  initial begin
    vecs[0] = '{16'h1A2F, 48'h3141_3246_0D0A, 0, 1'b0, 16'h0000};
    vecs[1] = '{16'h0000, 48'h3030_3030_0D0A, 0, 1'b1, 16'hFFFF};
    vecs[2] = '{16'hFFFF, 48'h4646_4646_0D0A, 0, 1'b0, 16'h0000};
    vecs[3] = '{16'h1234, 48'h3132_3334_0D0A, 2, 1'b0, 16'h0000};
    vecs[4] = '{16'h00C3, 48'h3030_4333_0D0A, 1, 1'b0, 16'h0000};
    vecs[5] = '{16'h9A05, 48'h3941_3035_0D0A, 0, 1'b0, 16'h0000};

    #1 reset = 1'b1;
    #1 check("reset values {txp,ready,busy}", 32'({txp, in_ready, busy}), 32'(3'b110));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check(50, "idle 50 cycles after reset");

    for (int i = 0; i < 6; i++) begin
      run_msg(vecs[i], i);
      if (!vecs[i].hold_next) idle_check(5, $sformatf("idle gap after msg%0d", i));
    end

    // Reset in the middle of char 3 data bit 0 ('4' = 0x34, bit0 = 0).
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30 * D + D + D / 2 - 1) @(negedge clk);
    check("txp low before mid-frame reset", 32'(txp), 32'(1'b0));
    #1 reset = 1'b1;
    #1 check("async reset {txp,ready,busy}", 32'({txp, in_ready, busy}), 32'(3'b110));
    @(negedge clk);
    reset = 1'b0;
    idle_check(3, "idle after mid-frame reset");
    run_msg('{16'h0007, 48'h3030_3037_0D0A, 0, 1'b0, 16'h0000}, 6);
    idle_check(5, "idle at end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
